// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin share of one I2C register-write engine between two requesters
module i2c_write_arbiter #(
  parameter logic [15:0] GAP_CYCLES     = 16'd500,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] id0,
  input  logic [7:0] reg0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] id1,
  input  logic [7:0] reg1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       ack_timeout,
  output logic       eng_start,
  output logic [7:0] eng_id,
  output logic [7:0] eng_reg,
  output logic [7:0] eng_data,
  input  logic       eng_done,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state, state_nx;
  logic last, cur, gnt, any_req, t_hit, g_hit, fin, to_fire, grant;
  logic [15:0] gcnt;
  logic [23:0] tcnt;
  assign any_req   = req0 | req1;
  assign gnt       = (req0 & req1) ? ~last : req1;
  assign grant     = state == IDLE && any_req;
  // terminal count is when the incremented counter would reach TIMEOUT_CYCLES-1
  assign t_hit     = {1'b0, tcnt} + 25'd2 >= {1'b0, TIMEOUT_CYCLES};
  assign g_hit     = {1'b0, gcnt} + 17'd1 >= {1'b0, GAP_CYCLES};
  assign fin       = state == WAIT && (eng_done || t_hit);
  assign to_fire   = state == WAIT && !eng_done && t_hit;
  assign eng_start = state == START;
  assign busy      = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? START : IDLE;
      START:   state_nx = WAIT;
      WAIT:    state_nx = fin ? GAP : WAIT;
      GAP:     state_nx = g_hit ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      cur         <= 1'b0;
      gcnt        <= '0;
      tcnt        <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      ack_timeout <= 1'b0;
      timeout_err <= 1'b0;
      eng_id      <= '0;
      eng_reg     <= '0;
      eng_data    <= '0;
    end else begin
      state       <= state_nx;
      ack0        <= fin && !cur;
      ack1        <= fin && cur;
      ack_timeout <= to_fire;
      timeout_err <= to_fire || (timeout_err && !err_clr);
      tcnt        <= state == WAIT ? (tcnt + 24'd1 >= TIMEOUT_CYCLES ? tcnt : tcnt + 24'd1) : 24'd0;
      gcnt        <= state == GAP ? (g_hit ? gcnt : gcnt + 16'd1) : 16'd0;
      if (grant) begin
        cur      <= gnt;
        last     <= gnt;
        eng_id   <= gnt ? id1 : id0;
        eng_reg  <= gnt ? reg1 : reg0;
        eng_data <= gnt ? data1 : data0;
      end
    end
  end
endmodule
